// File: rtl/dual_s2p_rx.sv
// Dual-lane serial-to-parallel receiver: rebuilds W_A/W_B-bit words from two MSB-first
// serial lines sharing one frame strobe and bit enable, flagging restarts and timeouts.
module dual_s2p_rx #(
    parameter int W_A     = 24,
    parameter int W_B     = 16,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           bit_en,
    input  logic           frame_start,
    input  logic           sdata24,
    input  logic           sdata16,
    output logic [W_A-1:0] pdata24,
    output logic [W_B-1:0] pdata16,
    output logic           valid24,
    output logic           valid16,
    output logic           busy,
    output logic           frame_err
);
    localparam int CW = $clog2(W_A + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state, state_nxt;
    logic [W_A-1:0] sr_a, sr_a_nxt;
    logic [W_B-1:0] sr_b, sr_b_nxt;
    logic [CW-1:0]  bit_cnt, cnt_nxt;
    logic [7:0]     tmo_cnt;
    logic           load, shift, done_a, done_b, err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (bit_en && frame_start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // a restart sample doubles as the MSB of the new frame
                if (bit_en && frame_start) begin
                    load = 1'b1;
                    err  = 1'b1;
                end else if (bit_en) begin
                    shift = 1'b1;
                end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
                    err       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        cnt_nxt  = load ? CW'(1) : bit_cnt + CW'(1);
        done_b   = (load || shift) && (cnt_nxt == CW'(W_B));
        done_a   = (load || shift) && (cnt_nxt == CW'(W_A));
        if (done_a) state_nxt = IDLE;

        sr_a_nxt = load ? W_A'(sdata24) : ((sr_a << 1) | W_A'(sdata24));
        // lane B freezes once it holds W_B bits
        if (load)
            sr_b_nxt = W_B'(sdata16);
        else if (shift && (bit_cnt < CW'(W_B)))
            sr_b_nxt = (sr_b << 1) | W_B'(sdata16);
        else
            sr_b_nxt = sr_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_a      <= '0;
            sr_b      <= '0;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            pdata24   <= '0;
            pdata16   <= '0;
            valid24   <= 1'b0;
            valid16   <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid24   <= done_a;
            valid16   <= done_b;
            frame_err <= err;
            // busy spans the frame up to and including its valid24 cycle
            busy      <= (state_nxt == SHIFT) || done_a;
            if (load || shift) begin
                sr_a    <= sr_a_nxt;
                sr_b    <= sr_b_nxt;
                bit_cnt <= cnt_nxt;
            end
            if (done_a) pdata24 <= sr_a_nxt;
            if (done_b) pdata16 <= sr_b_nxt;
            if (state == SHIFT && state_nxt == SHIFT && !bit_en)
                tmo_cnt <= tmo_cnt + 8'd1;
            else
                tmo_cnt <= '0;
        end
    end
endmodule
